// File: rtl/ahb_master_if.sv
// Request/response handshake plus AHB-Lite master bus for ahb_master.
interface ahb_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [2:0]  req_size;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [1:0]  htrans;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
    logic        hresp;

    modport master (
        input  req_valid, req_write, req_addr, req_size, req_wdata,
        input  hrdata, hready, hresp,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output haddr, hwrite, hsize, htrans, hburst, hwdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_size, req_wdata,
        output hrdata, hready, hresp,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  haddr, hwrite, hsize, htrans, hburst, hwdata
    );
endinterface

// File: rtl/ahb_master.sv
// Single-transfer AHB-Lite master: request port mapped onto an address/data
// pipeline with two-cycle ERROR recovery and a data-phase watchdog.
module ahb_master #(
    parameter int unsigned WAIT_LIMIT = 16
) (
    input  logic         hclk,
    input  logic         hresetn,
    ahb_master_if.master bus
);

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [7:0] WAIT_LAST     = 8'(WAIT_LIMIT - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_ERR2, ST_REISSUE} state_t;

    state_t      state_q, state_d;
    logic        a_valid_q, a_valid_d;
    logic [31:0] haddr_q, haddr_d;
    logic        hwrite_q, hwrite_d;
    logic [2:0]  hsize_q, hsize_d;
    logic [31:0] a_wdata_q, a_wdata_d;
    logic [1:0]  htrans_q, htrans_d;
    logic        d_valid_q, d_valid_d;
    logic        d_write_q, d_write_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic [7:0]  wcnt_q, wcnt_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        rsp_timeout_q, rsp_timeout_d;

    logic adv, acc, ok_done, err1, err_done, timeout, abort, req_ready;

    always_comb begin
        ok_done   = d_valid_q && bus.hready && !bus.hresp;
        err1      = d_valid_q && !bus.hready && bus.hresp;
        err_done  = d_valid_q && bus.hready && bus.hresp;
        timeout   = d_valid_q && !bus.hready && !bus.hresp && (wcnt_q == WAIT_LAST);
        // D retired while the pending entry could not advance; it is re-driven via REISSUE
        abort     = err_done || timeout || (state_q == ST_ERR2 && ok_done);
        adv       = a_valid_q && (htrans_q == HTRANS_NONSEQ) && bus.hready && !bus.hresp;
        req_ready = (!a_valid_q || adv) && !err1 && !timeout;
        acc       = bus.req_valid && req_ready;

        haddr_d   = haddr_q;
        hwrite_d  = hwrite_q;
        hsize_d   = hsize_q;
        a_wdata_d = a_wdata_q;
        if (acc) begin
            haddr_d   = bus.req_addr;
            hwrite_d  = bus.req_write;
            hsize_d   = bus.req_size;
            a_wdata_d = bus.req_wdata;
        end
        a_valid_d = acc || (a_valid_q && !adv);

        d_valid_d = adv || (d_valid_q && !(ok_done || err_done || timeout));
        d_write_d = adv ? hwrite_q : d_write_q;
        hwdata_d  = adv ? a_wdata_q : hwdata_q;
        wcnt_d    = (d_valid_q && !bus.hready && !timeout) ? wcnt_q + 8'd1 : '0;

        rsp_valid_d   = ok_done || err_done || timeout;
        rsp_err_d     = err_done || timeout;
        rsp_timeout_d = timeout;
        rsp_rdata_d   = (ok_done && !d_write_q) ? bus.hrdata : '0;

        if (acc)
            htrans_d = HTRANS_NONSEQ;
        else if (adv || err1 || abort)
            htrans_d = HTRANS_IDLE;
        else if (state_q == ST_REISSUE)
            htrans_d = HTRANS_NONSEQ;
        else
            htrans_d = htrans_q;

        if (err1)
            state_d = ST_ERR2;
        else if (abort)
            state_d = a_valid_q ? ST_REISSUE : (acc ? ST_ACTIVE : ST_IDLE);
        else if (state_q == ST_REISSUE)
            state_d = ST_ACTIVE;
        else
            state_d = (a_valid_d || d_valid_d) ? ST_ACTIVE : ST_IDLE;
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q       <= ST_IDLE;
            a_valid_q     <= 1'b0;
            haddr_q       <= '0;
            hwrite_q      <= 1'b0;
            hsize_q       <= '0;
            a_wdata_q     <= '0;
            htrans_q      <= HTRANS_IDLE;
            d_valid_q     <= 1'b0;
            d_write_q     <= 1'b0;
            hwdata_q      <= '0;
            wcnt_q        <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            a_valid_q     <= a_valid_d;
            haddr_q       <= haddr_d;
            hwrite_q      <= hwrite_d;
            hsize_q       <= hsize_d;
            a_wdata_q     <= a_wdata_d;
            htrans_q      <= htrans_d;
            d_valid_q     <= d_valid_d;
            d_write_q     <= d_write_d;
            hwdata_q      <= hwdata_d;
            wcnt_q        <= wcnt_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign bus.req_ready   = req_ready;
    assign bus.haddr       = haddr_q;
    assign bus.hwrite      = hwrite_q;
    assign bus.hsize       = hsize_q;
    assign bus.htrans      = htrans_q;
    assign bus.hburst      = 3'b000;
    assign bus.hwdata      = hwdata_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.rsp_err     = rsp_err_q;
    assign bus.rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_ahb_master.sv
// Bench for ahb_master: scripted and random requests against a bench-side slave,
// checked by a transaction-level model of bus phases, handshakes and responses.
module tb_ahb_master;

    localparam int unsigned LIMIT = 16;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } req_t;

    // kind: 0 OKAY, 1 two-cycle ERROR, 2 never ready (watchdog), 3 one-cycle ERROR
    typedef struct {
        int unsigned kind;
        int unsigned waits;
        logic [31:0] rdata;
    } plan_t;

    logic hclk = 1'b0;
    logic hresetn;

    ahb_master_if bus ();

    ahb_master #(.WAIT_LIMIT(LIMIT)) dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .bus     (bus)
    );

    always #5 hclk = ~hclk;

    int n_cmp = 0;
    int n_err = 0;

    req_t        script_q[$];
    plan_t       plan_q[$];
    req_t        pend_q[$];
    req_t        cur;
    plan_t       cur_plan;
    req_t        drv;
    bit          dp_active = 0;
    int unsigned dp_k = 0;
    bit          blank = 0;
    bit          rsp_due = 0;
    bit          exp_err = 0;
    bit          exp_to = 0;
    logic [31:0] exp_rdata = '0;
    bit          req_acc = 0;
    bit          rand_en = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic plan_t rand_plan(input logic wr);
        plan_t p;
        int unsigned r;
        r = $urandom % 16;
        p.rdata = $urandom;
        if (r == 0) begin
            p.kind = 2; p.waits = LIMIT;
        end else if (r < 3) begin
            p.kind = 1; p.waits = $urandom % 3;
        end else if (r == 3 && wr) begin
            p.kind = 3; p.waits = $urandom % 2;
        end else begin
            p.kind = 0; p.waits = ($urandom % 3 == 0) ? $urandom % 4 : 0;
        end
        return p;
    endfunction

    // Evaluate the current cycle (sampled at negedge) and predict the coming edge.
    task automatic eval_cycle();
        bit exp_ns, addr_done, ok_now, e1_now, ed_now, to_now, exp_ready, dp_end;
        exp_ns = (pend_q.size() > 0) && !blank;
        check("htrans", {30'd0, bus.htrans}, exp_ns ? 32'd2 : 32'd0);
        if (exp_ns) begin
            check("haddr", bus.haddr, pend_q[0].addr);
            check("hwrite", {31'd0, bus.hwrite}, {31'd0, pend_q[0].wr});
            check("hsize", {29'd0, bus.hsize}, {29'd0, pend_q[0].size});
        end
        check("rsp_valid", {31'd0, bus.rsp_valid}, {31'd0, rsp_due});
        if (rsp_due) begin
            check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, exp_err});
            check("rsp_timeout", {31'd0, bus.rsp_timeout}, {31'd0, exp_to});
            if (!exp_err) check("rsp_rdata", bus.rsp_rdata, exp_rdata);
        end
        if (dp_active && cur.wr) check("hwdata", bus.hwdata, cur.wdata);

        ok_now    = dp_active && bus.hready && !bus.hresp;
        ed_now    = dp_active && bus.hready && bus.hresp;
        e1_now    = dp_active && !bus.hready && bus.hresp;
        to_now    = dp_active && cur_plan.kind == 2 && dp_k == LIMIT - 1;
        addr_done = exp_ns && bus.hready && !bus.hresp;
        exp_ready = (pend_q.size() == 0 || addr_done) && !e1_now && !to_now;
        check("req_ready", {31'd0, bus.req_ready}, {31'd0, exp_ready});

        dp_end    = ok_now || ed_now || to_now;
        rsp_due   = dp_end;
        exp_err   = ed_now || to_now;
        exp_to    = to_now;
        exp_rdata = (ok_now && !cur.wr) ? bus.hrdata : 32'd0;
        blank     = e1_now || ((ed_now || to_now) && pend_q.size() > 0);
        if (dp_end) dp_active = 0;
        else if (dp_active) dp_k++;
        if (addr_done) begin
            cur = pend_q.pop_front();
            cur_plan = (plan_q.size() > 0) ? plan_q.pop_front() : rand_plan(cur.wr);
            dp_active = 1;
            dp_k = 0;
        end
        req_acc = bus.req_valid && exp_ready;
        if (req_acc) pend_q.push_back(drv);
    endtask

    task automatic drive_cycle();
        bus.hrdata = $urandom;
        if (!dp_active) begin
            bus.hready = 1'b1; bus.hresp = 1'b0;
        end else begin
            case (cur_plan.kind)
                0: begin
                    bus.hresp  = 1'b0;
                    bus.hready = (dp_k >= cur_plan.waits);
                    if (dp_k == cur_plan.waits) bus.hrdata = cur_plan.rdata;
                end
                1: begin
                    bus.hresp  = (dp_k >= cur_plan.waits);
                    bus.hready = (dp_k > cur_plan.waits);
                end
                3: begin
                    bus.hresp  = (dp_k >= cur_plan.waits);
                    bus.hready = (dp_k >= cur_plan.waits);
                end
                default: begin
                    bus.hresp = 1'b0; bus.hready = 1'b0;
                end
            endcase
        end
        if (!(bus.req_valid && !req_acc)) begin
            if (script_q.size() > 0) begin
                drv = script_q.pop_front();
                bus.req_valid = 1'b1;
            end else begin
                drv.wr    = $urandom % 2;
                drv.addr  = $urandom;
                drv.size  = ($urandom % 8 == 0) ? 3'($urandom % 8) : 3'($urandom % 3);
                drv.wdata = $urandom;
                bus.req_valid = rand_en && ($urandom % 2 == 0);
            end
            bus.req_write = drv.wr;
            bus.req_addr  = drv.addr;
            bus.req_size  = drv.size;
            bus.req_wdata = drv.wdata;
        end
    endtask

    task automatic step();
        @(negedge hclk);
        eval_cycle();
        @(posedge hclk);
        #1;
        drive_cycle();
    endtask

    task automatic run_script(input int unsigned budget);
        int unsigned n;
        n = 0;
        do begin
            step();
            n++;
        end while (n < budget && (script_q.size() > 0 || pend_q.size() > 0 || dp_active ||
                                  bus.req_valid || rsp_due));
        check("drain_in_budget", {31'd0, (n < budget)}, 32'd1);
        step();
        step();
    endtask

    task automatic add_req(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int unsigned kind, input int unsigned waits,
                           input logic [31:0] rdata);
        req_t  r;
        plan_t p;
        r.wr = wr; r.addr = addr; r.size = 3'd2; r.wdata = wdata;
        p.kind = kind; p.waits = waits; p.rdata = rdata;
        script_q.push_back(r);
        plan_q.push_back(p);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_htrans"}, {30'd0, bus.htrans}, 32'd0);
        check({tag, "_haddr"}, bus.haddr, 32'd0);
        check({tag, "_hwrite"}, {31'd0, bus.hwrite}, 32'd0);
        check({tag, "_hsize"}, {29'd0, bus.hsize}, 32'd0);
        check({tag, "_hwdata"}, bus.hwdata, 32'd0);
        check({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
        check({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'd0);
        check({tag, "_rsp_err"}, {31'd0, bus.rsp_err}, 32'd0);
        check({tag, "_rsp_timeout"}, {31'd0, bus.rsp_timeout}, 32'd0);
        check({tag, "_hburst"}, {29'd0, bus.hburst}, 32'd0);
    endtask

    initial begin
        int unsigned n;
        hresetn       = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_size  = '0;
        bus.req_wdata = '0;
        bus.hready    = 1'b1;
        bus.hresp     = 1'b0;
        bus.hrdata    = '0;
        drv.wr = 1'b0; drv.addr = '0; drv.size = '0; drv.wdata = '0;
        cur = drv;
        cur_plan.kind = 0; cur_plan.waits = 0; cur_plan.rdata = '0;

        #12;
        check_reset_outputs("reset");
        @(posedge hclk);
        #1;
        hresetn = 1'b1;

        add_req(1'b0, 32'h0000_0040, 32'h0, 0, 0, 32'hDEAD_BEEF);
        run_script(40);
        add_req(1'b1, 32'h0000_0010, 32'h11, 0, 0, 32'h0);
        add_req(1'b1, 32'h0000_0014, 32'h22, 0, 0, 32'h0);
        run_script(40);
        add_req(1'b0, 32'h0000_0080, 32'h0, 0, 3, 32'h1234_5678);
        add_req(1'b0, 32'h0000_0084, 32'h0, 0, 0, 32'h8765_4321);
        run_script(40);
        add_req(1'b0, 32'h0000_0100, 32'h0, 1, 0, 32'hBAD0_BAD0);
        add_req(1'b0, 32'h0000_0104, 32'h0, 0, 0, 32'hC0DE_0104);
        run_script(40);
        add_req(1'b0, 32'h0000_0200, 32'h0, 2, LIMIT, 32'h0);
        add_req(1'b0, 32'h0000_0204, 32'h0, 0, 1, 32'h0000_0204);
        run_script(80);
        add_req(1'b1, 32'h0000_0300, 32'h33, 3, 1, 32'h0);
        add_req(1'b1, 32'h0000_0304, 32'h44, 0, 0, 32'h0);
        run_script(40);

        rand_en = 1;
        for (int i = 0; i < 1500; i++) step();
        rand_en = 0;
        run_script(200);

        add_req(1'b1, 32'h0000_0400, 32'hA5A5_5A5A, 0, 10, 32'h0);
        n = 0;
        do begin
            step();
            n++;
        end while (n < 40 && !(dp_active && dp_k == 4));
        check("reach_wait_state", {31'd0, (dp_active && dp_k == 4)}, 32'd1);
        #2;
        hresetn = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        script_q.delete();
        plan_q.delete();
        pend_q.delete();
        dp_active = 0; dp_k = 0; blank = 0; rsp_due = 0; req_acc = 0;
        bus.req_valid = 1'b0;
        bus.hready    = 1'b1;
        bus.hresp     = 1'b0;
        @(posedge hclk);
        #1;
        hresetn = 1'b1;
        for (int i = 0; i < 8; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ahb_master.md
AHB_MASTER -- requirements
Module: ahb_master

Interface
REQ-001 Parameter: WAIT_LIMIT, default 16, consecutive hready-low data-phase cycles before timeout abort (range 2..255).
REQ-002 hclk  input  1  bus clock; all state changes on rising edge.
REQ-003 hresetn  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  user request present.
REQ-005 req_ready  output  1  request accepted on edge where req_valid and req_ready are both 1.
REQ-006 req_write  input  1  1 = write, 0 = read.
REQ-007 req_addr  input  32  transfer address.
REQ-008 req_size  input  3  HSIZE encoding; only 0/1/2 (byte/half/word) legal.
REQ-009 req_wdata  input  32  write data.
REQ-010 rsp_valid  output  1  one-cycle completion pulse; no backpressure.
REQ-011 rsp_rdata  output  32  read data; valid with rsp_valid for reads.
REQ-012 rsp_err  output  1  transfer ended with ERROR or timeout.
REQ-013 rsp_timeout  output  1  transfer ended by watchdog.
REQ-014 haddr/hwrite/hsize  output  32/1/3  AHB address-phase signals.
REQ-015 htrans  output  2  IDLE 2'b00 or NONSEQ 2'b10 only.
REQ-016 hburst  output  3  constant SINGLE 3'b000.
REQ-017 hwdata  output  32  AHB write data, data phase.
REQ-018 hrdata/hready/hresp  input  32/1/1  muxed slave response (hresp 1 = ERROR).

Function
REQ-019 Two-stage pipeline: stage A = pending address phase, stage D = active data phase; transfer N+1 address phase SHALL overlap transfer N data phase.
REQ-020 req_ready = !A_valid OR (hready AND NOT hresp), and 0 in the first ERROR cycle and timeout cycle.
REQ-021 On acceptance: haddr/hwrite/hsize loaded from req_*, htrans = NONSEQ next cycle; otherwise htrans = IDLE when A empty.
REQ-022 Address phase completes on edge with hready=1 and hresp=0: A moves to D, hwdata driven from captured req_wdata from next cycle for the whole data phase.
REQ-023 Address signals SHALL hold stable while hready=0.
REQ-024 OKAY completion: edge with D_valid, hready=1, hresp=0 -> next cycle rsp_valid=1, rsp_err=0, rsp_rdata = hrdata sampled at that edge (reads) or 0 (writes).
REQ-025 ERROR cycle 1 (hresp=1, hready=0): htrans forced IDLE next cycle; pending A entry retained, not dropped.
REQ-026 ERROR cycle 2 (hresp=1, hready=1): rsp_valid=1, rsp_err=1 next cycle; retained A entry reissued as NONSEQ the following cycle.
REQ-027 States: IDLE, ACTIVE, ERR2 (between error cycles), REISSUE; ERR2 entered on error cycle 1, REISSUE on error cycle 2 if A valid, else IDLE.
REQ-028 Watchdog: counter increments each cycle D_valid and hready=0, clears on hready=1; when count reaches WAIT_LIMIT, D is retired with rsp_valid=1, rsp_err=1, rsp_timeout=1, counter cleared, pending A reissued per REQ-026.
REQ-029 Responses strictly in issue order; at most one rsp_valid per cycle.
REQ-030 Write to D with hresp=1 and hready=1 in same cycle (non-compliant slave) SHALL be treated as ERROR completion.
REQ-031 Illegal req_size (3..7) SHALL be accepted and issued unchanged; no checking.

Reset
REQ-032 hresetn low, asynchronously: htrans=IDLE, haddr=0, hwrite=0, hsize=0, hwdata=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0, A/D empty, counter 0, state IDLE.
REQ-033 Reset mid-transfer SHALL discard A and D with no response; req_ready=1 the first cycle after release.

Verification
REQ-034 Single read 0x0000_0040, slave hready=1, hrdata=0xDEAD_BEEF -> NONSEQ one cycle, rsp_valid two cycles after accept with rsp_rdata=0xDEAD_BEEF, rsp_err=0.
REQ-035 Back-to-back writes 0x10/0x14 data 0x11/0x22, zero wait -> htrans NONSEQ two consecutive cycles, hwdata 0x11 then 0x22, two rsp_valid pulses.
REQ-036 Read with 3 wait states -> haddr held, rsp_valid exactly 4 cycles after address phase completes, next accepted request issued only then.
REQ-037 Two-cycle ERROR on first of two pipelined reads -> htrans IDLE after cycle 1, rsp_err=1 once, second read reissued NONSEQ and completes OKAY.
REQ-038 hready held low 16 cycles, WAIT_LIMIT=16 -> rsp_err=1, rsp_timeout=1, htrans returns IDLE.
REQ-039 hresetn asserted during wait state -> outputs reach reset values without a clock edge, no rsp_valid after release.
